// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one dmem req/ack transaction per memory op and returns the extended load value.
// Optional macro LSU_TIMEOUT_EN adds a REQ watchdog that ends a stuck access with bus_err_o.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid_i,
  input  logic        mem_en_i,
  input  logic        mem_we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        ext_stall_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_unsigned;
  logic [31:0] r_load_data;

  logic        w_op;
  logic        w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  assign w_op = valid_i & mem_en_i;

  // Size 2'b11 falls into the default (word) arm everywhere.
  always_comb begin
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_wdata   = wdata_i;
    case (size_i)
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << addr_i[1:0];
        w_wdata   = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_aligned = ~addr_i[0];
        w_be      = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{wdata_i[15:0]}};
      end
      default: begin
        w_aligned = (addr_i[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = wdata_i;
      end
    endcase
  end

  assign w_shifted = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ext = dmem_rdata_i;
    case (r_size)
      2'b00:   w_ext = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = dmem_rdata_i;
    endcase
    if (r_we) begin
      w_ext = 32'd0;
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;
  assign bus_err_o = r_bus_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign bus_err_o        = 1'b0;
`endif

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_size      <= 2'd0;
      r_off       <= 2'd0;
      r_unsigned  <= 1'b0;
      r_load_data <= 32'd0;
`ifdef LSU_TIMEOUT_EN
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op && w_aligned) begin
            r_state    <= S_REQ;
            r_req      <= 1'b1;
            r_addr     <= {addr_i[31:2], 2'b00};
            r_we       <= mem_we_i;
            r_be       <= w_be;
            r_wdata    <= w_wdata;
            r_size     <= size_i;
            r_off      <= addr_i[1:0];
            r_unsigned <= unsigned_i;
`ifdef LSU_TIMEOUT_EN
            r_cnt      <= '0;
`endif
          end
        end
        S_REQ: begin
          if (dmem_ack_i) begin
            r_state     <= S_DONE;
            r_req       <= 1'b0;
            r_load_data <= w_ext;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= S_DONE;
            r_req       <= 1'b0;
            r_load_data <= 32'd0;
            r_bus_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_DONE: begin
          // Leaving DONE is the edge on which the pipeline advances.
          if (!ext_stall_i) begin
            r_state     <= S_IDLE;
            r_load_data <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            r_bus_err   <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_be_o    = r_be;
  assign load_data_o  = r_load_data;

  assign stall_o      = RST & (((r_state == S_IDLE) & w_op & w_aligned) | (r_state == S_REQ));
  assign misaligned_o = RST & (r_state == S_IDLE) & w_op & ~w_aligned;

endmodule
